alu_mp_sequencer: RTL and testbench
===================================

Name: alu_mp_sequencer

Overview:
Multi-precision add/subtract controller. It sequences the team's combinational 8-bit carry-lookahead adder byte by byte, lowest byte first, to produce WORDS*8-bit results. Carry is chained through a register between bytes. It accepts one operation at a time over a valid/ready handshake and reports the result plus carry, signed-overflow and zero flags. The adder is instantiated outside this block and connected through the add_* ports.

Parameters:
WORDS, 4, operand width in bytes (legal range 1..16); the result is WORDS*8 bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start_valid  input  1  requester presents an operation.
start_ready  output  1  block can accept; high only in IDLE.
op_a  input  8*WORDS  operand A.
op_b  input  8*WORDS  operand B.
op_sub  input  1  0 = A+B, 1 = A-B.
op_sat  input  1  saturate request; used only with ALU_SEQ_SAT_EN.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.
result  output  8*WORDS  sum or difference.
res_cout  output  1  final carry out; for subtract, 1 = no borrow.
res_ov  output  1  signed overflow.
res_zero  output  1  result == 0.
add_a  output  8  adder operand A byte.
add_b  output  8  adder operand B byte, uninverted.
add_cin  output  1  adder carry in.
add_binv  output  1  adder B-invert control (= latched op_sub).
add_sum  input  8  adder sum byte (combinational, same cycle).
add_cout  input  1  adder carry out.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset state: FSM = IDLE. result, res_cout, res_ov, res_zero, res_valid, byte index, and carry register are all 0. start_ready = 1 after reset. add_* outputs are 0 in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start_valid & start_ready: latch op_a, op_b, op_sub, op_sat.
  - Set idx = 0 and carry_reg = op_sub (the +1 for two's-complement subtract).
  - Go to RUN.
- RUN, one byte per cycle:
  - Drive add_a = A[idx], add_b = B[idx], add_cin = carry_reg, add_binv = latched op_sub.
  - On the clock edge: result byte idx <= add_sum, carry_reg <= add_cout, idx <= idx+1.
  - On the cycle with idx == WORDS-1, also compute flags and go to DONE.
  - res_cout = the final add_cout.
  - res_ov = (A.msb == B'.msb) & (add_sum[7] != A.msb), where B' = ~B when subtracting, else B.
  - res_zero is computed on the final (post-saturation) result.
- DONE:
  - res_valid = 1; result and flags are held stable.
  - On res_ready, go to IDLE and drop res_valid. result and flags keep their values until the next operation completes.
- Latency: handshake in cycle 0, RUN in cycles 1..WORDS, res_valid from cycle WORDS+1. WORDS=1 gives a single RUN cycle.
- Throughput: a new start is accepted no earlier than the cycle after the res_ready handshake. start_valid is ignored while not IDLE.
- Operands are sampled only at the handshake. Later changes to op_* have no effect.
- rst_n asserted mid-RUN or in DONE: immediate return to reset state. The partial result is discarded and no res_valid pulse occurs.

Optional Feature:
ALU_SEQ_SAT_EN
- Defined: when latched op_sat = 1, unsigned saturation is applied on entry to DONE.
  - Add with final carry = 1: result becomes all-ones.
  - Subtract with final carry = 0 (borrow): result becomes all-zeros.
  - res_cout and res_ov report the raw, unsaturated arithmetic.
  - res_zero reflects the saturated result.
- Undefined: op_sat is ignored (no logic uses it), and result is always the raw wrap-around value.

Test Plan:
- WORDS=4, add 0x000000FF + 0x00000001 -> result 0x00000100, cout=0, ov=0, zero=0, res_valid first high 5 cycles after handshake. Check add_cin = 0,1,0,0 across RUN cycles.
- Sub 0x00000000 - 0x00000001 -> 0xFFFFFFFF, cout=0, ov=0. Check add_binv = 1 and first add_cin = 1.
- Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, ov=1, cout=0. Sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, ov=1, cout=1.
- Add 0xFFFFFFFF + 0x00000001 -> 0x00000000, cout=1, zero=1. With ALU_SEQ_SAT_EN and op_sat=1 -> 0xFFFFFFFF, cout=1, zero=0.
- Hold res_ready low for 3 cycles in DONE -> result and flags stable, start_ready=0, a concurrent start_valid is ignored. Release -> IDLE next cycle, the next op is accepted.
- Pulse rst_n low during the 2nd RUN cycle -> all outputs 0 immediately, start_ready=1 after release, no res_valid is seen.

Source files
------------

// File: rtl/alu_mp_sequencer.sv
// Multi-precision add/subtract sequencer driving an external 8-bit adder byte by byte, LSB first.
// Optional unsigned saturation is compiled in with `define ALU_SEQ_SAT_EN.
module alu_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [8*WORDS-1:0] op_a,
    input  logic [8*WORDS-1:0] op_b,
    input  logic               op_sub,
    input  logic               op_sat,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [8*WORDS-1:0] result,
    output logic               res_cout,
    output logic               res_ov,
    output logic               res_zero,
    output logic [7:0]         add_a,
    output logic [7:0]         add_b,
    output logic               add_cin,
    output logic               add_binv,
    input  logic [7:0]         add_sum,
    input  logic               add_cout
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [WORDS-1:0][7:0]  a_reg, b_reg, acc, acc_fin, res_fin;
    logic                   sub_reg;
    logic                   carry_reg;
    logic [IDX_W-1:0]       idx;
    logic                   last;
    logic                   ov_fin;

`ifdef ALU_SEQ_SAT_EN
    logic                   sat_reg;
`else
    logic                   unused_sat;
    assign unused_sat = op_sat;
`endif

    assign last        = (idx == IDX_W'(WORDS-1));
    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);

    // Adder drive is live only in RUN; everything else sees zeros.
    always_comb begin
        state_nxt = state;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        add_binv  = 1'b0;
        case (state)
            IDLE: if (start_valid) state_nxt = RUN;
            RUN: begin
                add_a    = a_reg[idx];
                add_b    = b_reg[idx];
                add_cin  = carry_reg;
                add_binv = sub_reg;
                if (last) state_nxt = DONE;
            end
            DONE: if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Final-byte view of the result plus flags, used on the last RUN cycle.
    always_comb begin
        acc_fin      = acc;
        acc_fin[idx] = add_sum;
        res_fin      = acc_fin;
`ifdef ALU_SEQ_SAT_EN
        if (sat_reg) begin
            if (!sub_reg && add_cout)
                res_fin = '1;
            else if (sub_reg && !add_cout)
                res_fin = '0;
        end
`endif
    end

    assign ov_fin = (a_reg[WORDS-1][7] == (b_reg[WORDS-1][7] ^ sub_reg)) &
                    (add_sum[7] != a_reg[WORDS-1][7]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            result    <= '0;
            res_cout  <= 1'b0;
            res_ov    <= 1'b0;
            res_zero  <= 1'b0;
`ifdef ALU_SEQ_SAT_EN
            sat_reg   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start_valid) begin
                    a_reg     <= op_a;
                    b_reg     <= op_b;
                    sub_reg   <= op_sub;
                    carry_reg <= op_sub;  // +1 of two's-complement subtract
                    idx       <= '0;
`ifdef ALU_SEQ_SAT_EN
                    sat_reg   <= op_sat;
`endif
                end
                RUN: begin
                    acc[idx]  <= add_sum;
                    carry_reg <= add_cout;
                    if (last) begin
                        idx      <= '0;
                        result   <= res_fin;
                        res_cout <= add_cout;
                        res_ov   <= ov_fin;
                        res_zero <= (res_fin == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Directed bench for alu_mp_sequencer (WORDS=4) with a behavioural 8-bit adder on the add_* ports.
module tb_alu_mp_sequencer;
    localparam int WORDS = 4;
    localparam int W     = WORDS*8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0, start_ready;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         op_sub = 1'b0, op_sat = 1'b0;
    logic         res_valid, res_ready = 1'b0;
    logic [W-1:0] result;
    logic         res_cout, res_ov, res_zero;
    logic [7:0]   add_a, add_b, add_sum;
    logic         add_cin, add_binv, add_cout;
    logic [8:0]   add_full;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign add_full = {1'b0, add_a} + {1'b0, (add_binv ? ~add_b : add_b)} + {8'b0, add_cin};
    assign add_sum  = add_full[7:0];
    assign add_cout = add_full[8];

    alu_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_sat(op_sat),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .res_cout(res_cout), .res_ov(res_ov), .res_zero(res_zero),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_binv(add_binv),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Called at a negedge in IDLE; returns at the negedge where res_valid is first seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic sat, output int lat, output logic [3:0] cin_tr,
                          output logic binv1);
        lat = 0; cin_tr = '0; binv1 = 1'b0;
        op_a = a; op_b = b; op_sub = sub; op_sat = sat; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        op_a = ~a; op_b = ~b; op_sub = ~sub;  // must not affect the operation in flight
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k <= 4) cin_tr[k-1] = add_cin;
            if (k == 1) binv1 = add_binv;
            if (res_valid) begin lat = k; break; end
        end
    endtask

    task automatic finish_op();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL reset start_ready got %b want 1", start_ready); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset res_valid got %b want 0", res_valid); end
        vectors++; if ({result, res_cout, res_ov, res_zero} !== '0) begin miscompares++; $display("FAIL reset result/flags got %h %b%b%b want 0", result, res_cout, res_ov, res_zero); end
        vectors++; if ({add_a, add_b, add_cin, add_binv} !== '0) begin miscompares++; $display("FAIL reset add_* got %h %h %b %b want 0", add_a, add_b, add_cin, add_binv); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_carry_chain();
        int lat; logic [3:0] tr; logic bi;
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat, tr, bi);
        vectors++; if (lat !== WORDS+1) begin miscompares++; $display("FAIL carry latency got %0d want %0d", lat, WORDS+1); end
        vectors++; if (tr !== 4'b0010) begin miscompares++; $display("FAIL carry cin_trace got %b want 0010", tr); end
        vectors++; if (result !== 32'h0000_0100) begin miscompares++; $display("FAIL carry result got %h want 00000100", result); end
        vectors++; if ({res_cout, res_ov, res_zero} !== 3'b000) begin miscompares++; $display("FAIL carry flags got %b want 000", {res_cout, res_ov, res_zero}); end
        finish_op();
    endtask

    task automatic test_sub_borrow();
        int lat; logic [3:0] tr; logic bi;
        run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, lat, tr, bi);
        vectors++; if (bi !== 1'b1) begin miscompares++; $display("FAIL sub add_binv got %b want 1", bi); end
        vectors++; if (tr !== 4'b0001) begin miscompares++; $display("FAIL sub cin_trace got %b want 0001", tr); end
        vectors++; if (result !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sub result got %h want ffffffff", result); end
        vectors++; if ({res_cout, res_ov, res_zero} !== 3'b000) begin miscompares++; $display("FAIL sub flags got %b want 000", {res_cout, res_ov, res_zero}); end
        finish_op();
    endtask

    task automatic test_overflow();
        int lat; logic [3:0] tr; logic bi;
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, tr, bi);
        vectors++; if (result !== 32'h8000_0000) begin miscompares++; $display("FAIL ov_add result got %h want 80000000", result); end
        vectors++; if ({res_cout, res_ov, res_zero} !== 3'b010) begin miscompares++; $display("FAIL ov_add flags got %b want 010", {res_cout, res_ov, res_zero}); end
        finish_op();
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, lat, tr, bi);
        vectors++; if (result !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL ov_sub result got %h want 7fffffff", result); end
        vectors++; if ({res_cout, res_ov, res_zero} !== 3'b110) begin miscompares++; $display("FAIL ov_sub flags got %b want 110", {res_cout, res_ov, res_zero}); end
        finish_op();
    endtask

    task automatic test_wrap_sat();
        int lat; logic [3:0] tr; logic bi;
        logic [W-1:0] exp_add, exp_sub;
        logic         exp_zadd, exp_zsub;
`ifdef ALU_SEQ_SAT_EN
        exp_add = 32'hFFFF_FFFF; exp_zadd = 1'b0;
        exp_sub = 32'h0000_0000; exp_zsub = 1'b1;
`else
        exp_add = 32'h0000_0000; exp_zadd = 1'b1;
        exp_sub = 32'hFFFF_FFFF; exp_zsub = 1'b0;
`endif
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, tr, bi);
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL wrap result got %h want 00000000", result); end
        vectors++; if ({res_cout, res_ov, res_zero} !== 3'b101) begin miscompares++; $display("FAIL wrap flags got %b want 101", {res_cout, res_ov, res_zero}); end
        finish_op();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, lat, tr, bi);
        vectors++; if (result !== exp_add) begin miscompares++; $display("FAIL sat_add result got %h want %h", result, exp_add); end
        vectors++; if ({res_cout, res_ov, res_zero} !== {2'b10, exp_zadd}) begin miscompares++; $display("FAIL sat_add flags got %b want %b", {res_cout, res_ov, res_zero}, {2'b10, exp_zadd}); end
        finish_op();
        run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, lat, tr, bi);
        vectors++; if (result !== exp_sub) begin miscompares++; $display("FAIL sat_sub result got %h want %h", result, exp_sub); end
        vectors++; if ({res_cout, res_ov, res_zero} !== {2'b00, exp_zsub}) begin miscompares++; $display("FAIL sat_sub flags got %b want %b", {res_cout, res_ov, res_zero}, {2'b00, exp_zsub}); end
        finish_op();
    endtask

    task automatic test_back_to_back();
        int lat; logic [3:0] tr; logic bi;
        int lat2;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat, tr, bi);
        // Try to start a new op while DONE is stalled.
        op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0002; op_sub = 1'b0; op_sat = 1'b0; start_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++; if ({res_valid, start_ready} !== 2'b10) begin miscompares++; $display("FAIL hold%0d valid/ready got %b want 10", k, {res_valid, start_ready}); end
            vectors++; if ({result, res_cout, res_ov, res_zero} !== {32'h2345_6789, 3'b000}) begin miscompares++; $display("FAIL hold%0d result got %h %b%b%b want 23456789 000", k, result, res_cout, res_ov, res_zero); end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        vectors++; if ({res_valid, start_ready} !== 2'b01) begin miscompares++; $display("FAIL release valid/ready got %b want 01", {res_valid, start_ready}); end
        vectors++; if (result !== 32'h2345_6789) begin miscompares++; $display("FAIL release result got %h want 23456789", result); end
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat2 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (res_valid) begin lat2 = k; break; end
        end
        vectors++; if (lat2 !== WORDS+1) begin miscompares++; $display("FAIL b2b latency got %0d want %0d", lat2, WORDS+1); end
        vectors++; if ({result, res_cout, res_ov, res_zero} !== {32'h0000_0001, 3'b100}) begin miscompares++; $display("FAIL b2b result got %h %b%b%b want 00000001 100", result, res_cout, res_ov, res_zero); end
        finish_op();
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        int lat; logic [3:0] tr; logic bi;
        op_a = 32'h0101_0101; op_b = 32'h0101_0101; op_sub = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #2;  // now in the 2nd RUN cycle
        rst_n = 1'b0;
        #1;
        vectors++; if ({result, res_cout, res_ov, res_zero} !== '0) begin miscompares++; $display("FAIL rst_mid result/flags got %h %b%b%b want 0", result, res_cout, res_ov, res_zero); end
        vectors++; if ({add_a, add_b, add_cin, add_binv, res_valid} !== '0) begin miscompares++; $display("FAIL rst_mid add_*/valid got %h %h %b %b %b want 0", add_a, add_b, add_cin, add_binv, res_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen = seen | res_valid;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid res_valid seen got %b want 0", seen); end
        vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid start_ready got %b want 1", start_ready); end
        run_op(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, lat, tr, bi);
        vectors++; if ({result, res_cout, res_ov, res_zero} !== {32'h0000_0002, 3'b100}) begin miscompares++; $display("FAIL post_rst result got %h %b%b%b want 00000002 100", result, res_cout, res_ov, res_zero); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_sub_borrow();
        test_overflow();
        test_wrap_sat();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
